decode_ibuf: RTL

//   Parametrised instruction buffer between the fetch/decode pipeline register and the decode

---
 rtl/decode_ibuf_pkg.sv | 17 +
 rtl/decode_ibuf_if.sv | 33 +++
 rtl/decode_ibuf_ram.sv | 39 +++
 rtl/decode_ibuf.sv | 130 +++++++++++++
 4 files changed

// File: rtl/decode_ibuf_pkg.sv
// Shared types for the decode instruction buffer: fetch entry layout, pointer/count typedefs
// and default geometry for top-level instantiation.
package decode_ibuf_pkg;

    localparam int IBUF_DEPTH   = 8;
    localparam int IBUF_FETCH_W = 2;
    localparam int IBUF_ISSUE_W = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_data_t;

    typedef logic [$clog2(IBUF_DEPTH)-1:0]   ibuf_ptr_t;
    typedef logic [$clog2(IBUF_DEPTH+1)-1:0] ibuf_cnt_t;

endpackage

// File: rtl/decode_ibuf_if.sv
// Fetch-side and decode-side bundle of the instruction buffer; master = fetch/decode
// pipeline, slave = decode_ibuf.
interface decode_ibuf_if
    import decode_ibuf_pkg::*;
#(
    parameter int FETCH_W = IBUF_FETCH_W,
    parameter int ISSUE_W = IBUF_ISSUE_W,
    parameter int DEPTH   = IBUF_DEPTH
);
    // Handshake: fetch lanes with in_valid set are taken only in a cycle where in_ready is 1
    // (in_ready depends on registered occupancy only); decode takes out_accept head entries
    // from those flagged by out_valid, anything beyond out_valid is ignored.
    logic [FETCH_W-1:0]               in_valid;
    fetch_data_t [FETCH_W-1:0]        in_data;
    logic                             in_ready;
    logic [ISSUE_W-1:0]               out_valid;
    fetch_data_t [ISSUE_W-1:0]        out_data;
    logic [$clog2(ISSUE_W+1)-1:0]     out_accept;
    logic                             flush;
    logic                             flush_keep;
    logic [$clog2(DEPTH+1)-1:0]       count;

    modport master (
        output in_valid, in_data, out_accept, flush, flush_keep,
        input  in_ready, out_valid, out_data, count
    );

    modport slave (
        input  in_valid, in_data, out_accept, flush, flush_keep,
        output in_ready, out_valid, out_data, count
    );

endinterface

// File: rtl/decode_ibuf_ram.sv
// Flop-based entry storage: FETCH_W write ports at consecutive addresses from wr_base,
// ISSUE_W asynchronous read ports at rd_base+i.
module decode_ibuf_ram
    import decode_ibuf_pkg::*;
#(
    parameter int DEPTH   = IBUF_DEPTH,
    parameter int FETCH_W = IBUF_FETCH_W,
    parameter int ISSUE_W = IBUF_ISSUE_W,
    localparam int PTR_W  = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic [FETCH_W-1:0]        wr_en,
    input  logic [PTR_W-1:0]          wr_base,
    input  fetch_data_t [FETCH_W-1:0] wr_data,
    input  logic [PTR_W-1:0]          rd_base,
    output fetch_data_t [ISSUE_W-1:0] rd_data
);
    // Payload carries no reset; validity is owned entirely by the occupancy count.
    fetch_data_t mem_q [DEPTH];
    fetch_data_t mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        for (int j = 0; j < FETCH_W; j++) begin
            if (wr_en[j]) mem_d[wr_base + PTR_W'(j)] = wr_data[j];
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        for (int i = 0; i < ISSUE_W; i++) begin
            rd_data[i] = mem_q[rd_base + PTR_W'(i)];
        end
    end

endmodule

// File: rtl/decode_ibuf.sv
// Multi-entry instruction buffer between fetch and decode with delay-slot preserving flush.
// Optional same-cycle bypass when empty is enabled by defining IBUF_BYPASS_EN.
module decode_ibuf
    import decode_ibuf_pkg::*;
#(
    parameter int FETCH_W = IBUF_FETCH_W,
    parameter int ISSUE_W = IBUF_ISSUE_W,
    parameter int DEPTH   = IBUF_DEPTH
) (
    input logic          clk,
    input logic          resetn,
    decode_ibuf_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int PAD_W = FETCH_W + ISSUE_W;

    logic [PTR_W-1:0]          head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic                      in_ready;
    logic                      bypass;
    int                        n_in, avail, k_pop, st_pop, byp_k, n_wr;
    logic [PAD_W-1:0]          vld_pad;
    fetch_data_t [PAD_W-1:0]   in_pad;
    logic [FETCH_W-1:0]        wr_en;
    fetch_data_t [FETCH_W-1:0] wr_data;
    fetch_data_t [ISSUE_W-1:0] rd_data;
    logic [ISSUE_W-1:0]        out_valid;
    fetch_data_t [ISSUE_W-1:0] out_data;

    decode_ibuf_ram #(.DEPTH(DEPTH), .FETCH_W(FETCH_W), .ISSUE_W(ISSUE_W)) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_base (tail_q),
        .wr_data (wr_data),
        .rd_base (head_q),
        .rd_data (rd_data)
    );

    always_comb begin
        in_ready = (int'(count_q) + FETCH_W) <= DEPTH;
        vld_pad  = '0;
        vld_pad[FETCH_W-1:0] = bus.in_valid;
        in_pad   = '0;
        in_pad[FETCH_W-1:0]  = bus.in_data;
        n_in = 0;
        for (int j = 0; j < FETCH_W; j++) begin
            if (bus.in_valid[j]) n_in = n_in + 1;
        end
        bypass = 1'b0;
`ifdef IBUF_BYPASS_EN
        bypass = (count_q == '0) && !bus.flush;
`endif
        // Entries decode can see this cycle: storage, or incoming lanes when bypassing.
        avail  = bypass ? (in_ready ? n_in : 0) : int'(count_q);
        k_pop  = (int'(bus.out_accept) < avail) ? int'(bus.out_accept) : avail;
        st_pop = bypass ? 0 : k_pop;
        byp_k  = bypass ? k_pop : 0;

        for (int i = 0; i < ISSUE_W; i++) begin
            out_valid[i] = i < avail;
            out_data[i]  = bypass ? in_pad[i] : rd_data[i];
        end

        wr_en   = '0;
        wr_data = bus.in_data;
        n_wr    = 0;
        head_d  = head_q + PTR_W'(st_pop);
        tail_d  = tail_q;
        count_d = count_q;
        if (bus.flush) begin
            if (!bus.flush_keep) begin
                head_d  = tail_q;
                count_d = '0;
            end else if (int'(count_q) - st_pop >= 1) begin
                // Delay slot already buffered: it becomes the only survivor.
                tail_d  = head_d + PTR_W'(1);
                count_d = CNT_W'(1);
            end else if (bus.in_valid[0]) begin
                wr_en[0]   = 1'b1;
                wr_data[0] = bus.in_data[0];
                head_d     = tail_q;
                tail_d     = tail_q + PTR_W'(1);
                count_d    = CNT_W'(1);
            end else begin
                head_d  = tail_q;
                count_d = '0;
            end
        end else begin
            if (in_ready) begin
                for (int j = 0; j < FETCH_W; j++) begin
                    if (vld_pad[j + byp_k]) begin
                        wr_en[j]   = 1'b1;
                        wr_data[j] = in_pad[j + byp_k];
                        n_wr       = n_wr + 1;
                    end
                end
            end
            tail_d  = tail_q + PTR_W'(n_wr);
            count_d = CNT_W'(int'(count_q) + n_wr - st_pop);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;
    assign bus.count     = count_q;

    always_ff @(posedge clk) begin
        if (resetn) begin
            a_push_ready: assert (!((|bus.in_valid) && !in_ready && !bus.flush))
                else $warning("decode_ibuf: push while not ready, entries dropped");
            a_accept_range: assert (int'(bus.out_accept) <= avail)
                else $warning("decode_ibuf: out_accept exceeds presented entries, clamped");
        end
    end

endmodule
